// File: rtl/n101_icache_refill.sv
// n101_icache_refill: I-cache line-fill engine.
// On a miss it issues one wrapping burst read and writes the returned words
// into the data RAM. The critical word is forwarded to the fetch unit as soon
// as it arrives. At the end of the line it reports completion or a bus error.
module n101_icache_refill #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MW         = 4,
  parameter int LINE_WORDS = 4,
  parameter int RAM_AW     = 8,
  localparam int LWB       = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [AW-1:0]     miss_addr,
  output logic              miss_rdy,
  output logic              bus_cmd_valid,
  input  logic              bus_cmd_ready,
  output logic [AW-1:0]     bus_cmd_addr,
  output logic [LWB-1:0]    bus_cmd_len,
  input  logic              bus_rsp_valid,
  input  logic [DW-1:0]     bus_rsp_data,
  input  logic              bus_rsp_err,
  output logic              bus_rsp_ready,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [MW-1:0]     ram_wem,
  output logic [DW-1:0]     ram_din,
  output logic              crit_valid,
  output logic [DW-1:0]     crit_data,
  output logic              fill_done,
  output logic              fill_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_FILL = 2'd2,
    S_LAST = 2'd3
  } state_e;

  localparam logic [LWB-1:0] LAST_BEAT = LWB'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [AW-1:2]     addr_q, addr_d;        // word address of the miss
  logic [LWB-1:0]    cnt_q, cnt_d;          // beats accepted so far
  logic              err_q, err_d;          // sticky: a bus error was seen
  logic              ram_cs_q, ram_cs_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0]     ram_din_q, ram_din_d;
  logic              crit_valid_q, crit_valid_d;
  logic [DW-1:0]     crit_data_q, crit_data_d;

  logic              beat_err;              // error seen up to and including this beat
  logic [LWB-1:0]    beat_off;              // line offset of the current beat
  logic              unused_addr_lsbs;

  // The fetch address is word-aligned, so the byte-offset bits carry nothing.
  assign unused_addr_lsbs = ^miss_addr[1:0];

  // Wrapping offset: the critical word first, then round the line.
  function automatic logic [LWB-1:0] wrap_offset(input logic [LWB-1:0] crit_off,
                                                 input logic [LWB-1:0] beat_cnt);
    return crit_off + beat_cnt;
  endfunction

  assign beat_err = err_q | bus_rsp_err;
  assign beat_off = wrap_offset(addr_q[2 +: LWB], cnt_q);

  // Next-state, beat bookkeeping and the values for the registered RAM/critical outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    ram_cs_d     = 1'b0;
    ram_addr_d   = {RAM_AW{1'b0}};
    ram_din_d    = {DW{1'b0}};
    crit_valid_d = 1'b0;
    crit_data_d  = {DW{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          addr_d  = miss_addr[AW-1:2];
          cnt_d   = {LWB{1'b0}};
          err_d   = 1'b0;
          state_d = S_CMD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD: begin
        if (bus_cmd_ready) begin
          state_d = S_FILL;
        end else begin
          state_d = S_CMD;
        end
      end
      S_FILL: begin
        if (bus_rsp_valid) begin
          err_d = beat_err;
          cnt_d = cnt_q + LWB'(1);
          // Once an error is seen the rest of the line is drained, not written.
          if (!beat_err) begin
            ram_cs_d   = 1'b1;
            ram_addr_d = {addr_q[RAM_AW+1 : 2+LWB], beat_off};
            ram_din_d  = bus_rsp_data;
          end else begin
            ram_cs_d   = 1'b0;
          end
          if ((cnt_q == {LWB{1'b0}}) && !bus_rsp_err) begin
            crit_valid_d = 1'b1;
            crit_data_d  = bus_rsp_data;
          end else begin
            crit_valid_d = 1'b0;
          end
          if (cnt_q == LAST_BEAT) begin
            state_d = S_LAST;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_LAST: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any line in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= {(AW-2){1'b0}};
      cnt_q        <= {LWB{1'b0}};
      err_q        <= 1'b0;
      ram_cs_q     <= 1'b0;
      ram_addr_q   <= {RAM_AW{1'b0}};
      ram_din_q    <= {DW{1'b0}};
      crit_valid_q <= 1'b0;
      crit_data_q  <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      ram_cs_q     <= ram_cs_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  // Handshakes and end-of-line pulses decode directly from the state register.
  assign miss_rdy      = (state_q == S_IDLE);
  assign bus_cmd_valid = (state_q == S_CMD);
  assign bus_cmd_addr  = {addr_q, 2'b00};
  assign bus_cmd_len   = bus_cmd_valid ? LAST_BEAT : {LWB{1'b0}};
  assign bus_rsp_ready = (state_q == S_FILL);
  assign ram_cs        = ram_cs_q;
  assign ram_we        = ram_cs_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wem       = {MW{ram_cs_q}};
  assign ram_din       = ram_din_q;
  assign crit_valid    = crit_valid_q;
  assign crit_data     = crit_data_q;
  assign fill_done     = (state_q == S_LAST) && !err_q;
  assign fill_err      = (state_q == S_LAST) && err_q;

endmodule

// File: tb/tb_n101_icache_refill.sv
// Scoreboard bench for n101_icache_refill: the driver pushes expected bus
// commands, RAM writes, critical words and line results; monitors pop and
// compare whenever the DUT presents them.
module tb_n101_icache_refill;

  localparam int AW = 32, DW = 32, MW = 4, LW = 4, RAM_AW = 8, LWB = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              miss_req = 1'b0;
  logic [AW-1:0]     miss_addr = '0;
  logic              miss_rdy;
  logic              bus_cmd_valid;
  logic              bus_cmd_ready = 1'b0;
  logic [AW-1:0]     bus_cmd_addr;
  logic [LWB-1:0]    bus_cmd_len;
  logic              bus_rsp_valid = 1'b0;
  logic [DW-1:0]     bus_rsp_data = '0;
  logic              bus_rsp_err = 1'b0;
  logic              bus_rsp_ready;
  logic              ram_cs, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [MW-1:0]     ram_wem;
  logic [DW-1:0]     ram_din;
  logic              crit_valid;
  logic [DW-1:0]     crit_data;
  logic              fill_done, fill_err;

  n101_icache_refill dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .miss_rdy(miss_rdy),
    .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready), .bus_cmd_addr(bus_cmd_addr),
    .bus_cmd_len(bus_cmd_len), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
    .bus_rsp_err(bus_rsp_err), .bus_rsp_ready(bus_rsp_ready), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wem(ram_wem), .ram_din(ram_din), .crit_valid(crit_valid),
    .crit_data(crit_data), .fill_done(fill_done), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  typedef struct { logic [RAM_AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { bit err; int lat; } end_t;

  wr_t           wr_q[$];
  logic [DW-1:0] crit_q[$];
  end_t          end_q[$];
  logic [AW-1:0] cmd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected output %0h, nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Reference: line index from the address, offset wraps from the critical word.
  function automatic logic [RAM_AW-1:0] ref_ram_addr(input logic [AW-1:0] a, input int k);
    int idx, off;
    idx = int'((a / 16) % 64);
    off = (int'((a / 4) % 4) + k) % LW;
    return RAM_AW'(idx * LW + off);
  endfunction

  // Monitor for RAM writes, critical word and line results, just after each edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (ram_cs) begin
        if (wr_q.size() == 0) unexpected("ram_write", 64'(ram_addr));
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("ram_addr", 64'(ram_addr), 64'(w.addr));
          check("ram_din", 64'(ram_din), 64'(w.data));
          check("ram_we_wem", 64'({ram_we, ram_wem}), 64'(5'h1F));
        end
      end else begin
        check("ram_idle_we_wem", 64'({ram_we, ram_wem}), 64'(0));
      end
      if (crit_valid) begin
        if (crit_q.size() == 0) unexpected("crit_valid", 64'(crit_data));
        else check("crit_data", 64'(crit_data), 64'(crit_q.pop_front()));
      end
      if (fill_done || fill_err) begin
        if (end_q.size() == 0) unexpected("fill_end", 64'({fill_done, fill_err}));
        else begin
          end_t e;
          e = end_q.pop_front();
          check("done_err", 64'({fill_done, fill_err}), 64'({~e.err, e.err}));
          check("miss_to_end_cycles", 64'(cyc - acc_cyc), 64'(e.lat));
        end
      end
    end
  end

  // Monitor for command handshakes, after the driver has set ready for this cycle.
  always @(negedge clk) begin
    #2;
    if (!rst && bus_cmd_valid && bus_cmd_ready) begin
      if (cmd_q.size() == 0) unexpected("bus_cmd", 64'(bus_cmd_addr));
      else begin
        check("bus_cmd_addr", 64'(bus_cmd_addr), 64'(cmd_q.pop_front()));
        check("bus_cmd_len", 64'(bus_cmd_len), 64'(LW - 1));
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_ctrl", 64'({miss_rdy, bus_cmd_valid, bus_rsp_ready, ram_cs, ram_we, crit_valid,
                           fill_done, fill_err, bus_cmd_len, ram_wem}), 64'(14'h2000));
    check("rst_data", {ram_din, crit_data}, 64'(0));
    check("rst_addr", 64'({bus_cmd_addr, ram_addr}), 64'(0));
  endtask

  // One miss: cmd_wait cycles of ready low, gap_mode 0=none 1=one idle per beat 2=random,
  // err_beat <0 for none, abort_after >=0 asserts reset after that many beats.
  task automatic run_miss(input logic [AW-1:0] a, input int cmd_wait, input int gap_mode,
                          input int err_beat, input int abort_after, input logic [DW-1:0] base);
    logic [DW-1:0] d[LW];
    int gaps[LW];
    int tot = 0, seen = 0, n = 0;
    for (int k = 0; k < LW; k++) begin
      d[k]    = (base != '0) ? base + DW'(k) : DW'($urandom);
      gaps[k] = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      tot += gaps[k];
    end
    for (int k = 0; k < LW; k++)
      if (err_beat < 0 || k < err_beat) wr_q.push_back('{addr: ref_ram_addr(a, k), data: d[k]});
    if (err_beat != 0) crit_q.push_back(d[0]);
    if (abort_after < 0) end_q.push_back('{err: (err_beat >= 0), lat: LW + 2 + cmd_wait + tot});
    cmd_q.push_back({a[AW-1:2], 2'b00});

    @(negedge clk);
    while (!miss_rdy && n < 20) begin @(negedge clk); n++; end
    check("miss_rdy_wait", 64'(miss_rdy), 64'(1));
    miss_req  = 1'b1;
    miss_addr = a;
    acc_cyc   = cyc;
    @(negedge clk);
    miss_req  = 1'b0;
    miss_addr = $urandom;
    // Command phase; junk response beats here must be ignored.
    for (int c = 0; c <= cmd_wait; c++) begin
      if (bus_cmd_valid) seen++;
      bus_rsp_valid = 1'($urandom_range(0, 1));
      bus_rsp_data  = $urandom;
      bus_rsp_err   = 1'($urandom_range(0, 1));
      bus_cmd_ready = (c == cmd_wait);
      @(negedge clk);
    end
    bus_cmd_ready = 1'b0;
    check("cmd_valid_cycles", 64'(seen), 64'(cmd_wait + 1));
    miss_req = 1'b1;  // must be ignored while the line is filling
    for (int k = 0; k < LW; k++) begin
      if (abort_after == k) break;
      for (int g = 0; g < gaps[k]; g++) begin
        bus_rsp_valid = 1'b0;
        bus_rsp_data  = $urandom;
        bus_rsp_err   = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      check("rsp_ready", 64'(bus_rsp_ready), 64'(1));
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = d[k];
      bus_rsp_err   = (k == err_beat);
      @(negedge clk);
    end
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    miss_req      = 1'b0;
    if (abort_after >= 0) begin
      rst = 1'b1;
      #1;
      check_reset_outputs();
      wr_q.delete();
      crit_q.delete();
      end_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      n = 0;
      while (end_q.size() != 0 && n < 10) begin @(negedge clk); n++; end
      check("line_end_seen", 64'(end_q.size()), 64'(0));
      check("writes_outstanding", 64'(wr_q.size()), 64'(0));
      check("crit_outstanding", 64'(crit_q.size()), 64'(0));
      check("cmd_outstanding", 64'(cmd_q.size()), 64'(0));
    end
  endtask

  initial begin
    int eb;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    run_miss(32'h0000_1000, 0, 0, -1, -1, 32'h0000_00A0);  // aligned, zero-wait
    run_miss(32'h0000_1008, 0, 0, -1, -1, 32'h0);          // wrap from offset 2
    run_miss(32'h0000_2004, 5, 1, -1, -1, 32'h0);          // stalled cmd, gapped beats
    run_miss(32'h0000_3000, 0, 0,  2, -1, 32'h0);          // error on beat 2
    run_miss(32'h0000_300C, 1, 0,  0, -1, 32'h0);          // error on beat 0
    run_miss(32'h0000_4004, 0, 0, -1,  2, 32'h0);          // reset after two beats
    run_miss(32'h0000_4004, 0, 0, -1, -1, 32'h0);          // recovers normally
    for (int i = 0; i < 24; i++) begin
      eb = int'($urandom_range(0, 7));
      run_miss($urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)), 2,
               (eb < LW) ? eb : -1, -1, 32'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/n101_icache_refill.md
# n101_icache_refill

Line-fill engine sitting directly upstream of the I-cache data RAM. On an I-cache miss it issues one wrapping burst read on the instruction-fetch bus and writes the returned words into the data RAM port (cs/we/addr/wem/din). It forwards the critical word to the fetch unit as soon as that word arrives, and signals line completion or bus error to the cache controller. One miss is outstanding at a time.

## Interface
- AW, 32: fetch address width.
- DW, 32: bus and RAM data width; fixed at 32 for this core.
- MW, 4: RAM write-mask width (DW/8).
- LINE_WORDS, 4: words per cache line; a power of 2, at least 2.
- RAM_AW, 8: data-RAM word-address width (index bits + log2(LINE_WORDS)).

- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- miss_req  in  1  miss request from the cache controller.
- miss_addr  in  AW  faulting fetch address (byte address, word-aligned).
- miss_rdy  out  1  high only in IDLE; a miss is accepted when miss_req & miss_rdy.
- bus_cmd_valid  out  1  burst command valid.
- bus_cmd_ready  in  1  bus accepts the command.
- bus_cmd_addr  out  AW  critical-word address: {miss_addr[AW-1:2], 2'b00}.
- bus_cmd_len  out  log2(LINE_WORDS)  beats minus one; constant LINE_WORDS-1; burst type is wrap.
- bus_rsp_valid  in  1  response beat valid.
- bus_rsp_data  in  DW  response data.
- bus_rsp_err  in  1  beat carries a bus error.
- bus_rsp_ready  out  1  high only in FILL.
- ram_cs, ram_we  out  1  data-RAM write strobe, registered.
- ram_addr  out  RAM_AW  data-RAM word address, registered.
- ram_wem  out  MW  all ones whenever ram_cs is high, else 0.
- ram_din  out  DW  write data, registered.
- crit_valid  out  1  one-cycle pulse: critical word is available.
- crit_data  out  DW  critical word.
- fill_done  out  1  one-cycle pulse: line written without error.
- fill_err  out  1  one-cycle pulse: a bus error occurred during the line.

## Operation
- States:
  - IDLE: on accept, latch miss_addr, clear beat count and the error flag, go to CMD.
  - CMD: hold bus_cmd_valid until bus_cmd_ready, then go to FILL.
  - FILL: accept beats. On the LINE_WORDS-th beat, go to LAST.
  - LAST: one cycle, then back to IDLE.
- Beat offset = (miss_addr word offset + beat count) mod LINE_WORDS. Wrap-around: with LINE_WORDS=4, a critical offset of 2 gives offsets 2,3,0,1.
- ram_addr = {miss_addr[RAM_AW+1 : 2+log2(LINE_WORDS)], beat offset}.
- Each accepted beat with no error seen so far (this beat included) is registered into ram_cs/we/addr/din for exactly one cycle.
- Error handling:
  - The first beat with bus_rsp_err sets the error flag.
  - That beat and every later beat are drained (bus_rsp_ready stays 1) but not written.
  - In LAST, fill_err pulses instead of fill_done.
- The critical word is beat 0. crit_valid pulses with it only if beat 0 is error-free.
- bus_rsp_valid outside FILL is ignored. miss_req outside IDLE is ignored and not queued.
- Async reset: state goes to IDLE, and every output goes to 0 except miss_rdy, which goes to 1. Reset mid-fill abandons the line. The cache controller must not mark the line valid without fill_done.

## Timing
- Miss accepted in cycle T. bus_cmd_valid is high from T+1; the earliest command handshake is at T+1.
- Beat k accepted in cycle B(k). The matching RAM write is driven in cycle B(k)+1.
- crit_valid/crit_data are high in cycle B(0)+1, together with the beat-0 write.
- The last beat at cycle L drives the FILL-to-LAST transition. The last write, and the fill_done or fill_err pulse, both occur in cycle L+1 (LAST).
- miss_rdy is high again in L+2.
- Back-to-back beats give one write per cycle with no bubbles.
- Minimum miss-to-done is LINE_WORDS+2 cycles after T.

## Test plan
- Aligned miss at 0x0000_1000, zero-wait bus, data 0xA0..0xA3:
  - one command with addr 0x1000, len 3;
  - writes to RAM addresses idx*4+0..3 with data 0xA0..0xA3 and wem=4'hF;
  - crit_data=0xA0;
  - fill_done 6 cycles after acceptance.
- Miss at 0x0000_1008:
  - command addr 0x1008;
  - writes at offsets 2,3,0,1 in that order;
  - crit_data equals the first beat.
- bus_cmd_ready held low for 5 cycles, then rsp_valid toggling every other cycle:
  - bus_cmd_valid stays asserted for those 5 cycles;
  - no write occurs before the first beat;
  - write count is exactly 4.
- bus_rsp_err on beat 2:
  - beats 0 and 1 are written;
  - beats 2 and 3 are drained, not written;
  - fill_err=1 and fill_done=0;
  - crit_valid still pulses.
- bus_rsp_err on beat 0: no RAM writes, no crit_valid, and a fill_err pulse.
- rst asserted after 2 beats:
  - all outputs go to 0 immediately and miss_rdy goes to 1;
  - no fill_done;
  - a subsequent miss completes normally.
